// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings and constants shared by the operand register file and
// the ALU it feeds.
//   WIDTH        : datapath width (32, fixed to match the ALU)
//   reg_fun_e    : 3-bit register function codes (FunSel of alu_operand_regfile)
//   reg_sel_e    : 3-bit read-select codes (OutASel / OutBSel)
//   alu_fun_e    : 5-bit ALU function codes
package cpu_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [2:0] {
    REG_DEC  = 3'b000,
    REG_INC  = 3'b001,
    REG_LOAD = 3'b010,
    REG_CLR  = 3'b011,
    REG_LDLB = 3'b100,
    REG_LDLH = 3'b101,
    REG_SHB  = 3'b110,
    REG_SEXH = 3'b111
  } reg_fun_e;

  typedef enum logic [2:0] {
    SEL_R1 = 3'd0,
    SEL_R2 = 3'd1,
    SEL_R3 = 3'd2,
    SEL_R4 = 3'd3,
    SEL_S1 = 3'd4,
    SEL_S2 = 3'd5,
    SEL_S3 = 3'd6,
    SEL_S4 = 3'd7
  } reg_sel_e;

  typedef enum logic [4:0] {
    ALU_PASS_A = 5'h00,
    ALU_PASS_B = 5'h01,
    ALU_NOT_A  = 5'h02,
    ALU_NOT_B  = 5'h03,
    ALU_ADD    = 5'h04,
    ALU_ADDC   = 5'h05,
    ALU_SUB    = 5'h06,
    ALU_AND    = 5'h07,
    ALU_OR     = 5'h08,
    ALU_XOR    = 5'h09,
    ALU_NAND   = 5'h0A,
    ALU_LSL    = 5'h0B,
    ALU_LSR    = 5'h0C,
    ALU_ASR    = 5'h0D,
    ALU_CSL    = 5'h0E,
    ALU_CSR    = 5'h0F
  } alu_fun_e;

endpackage

// File: rtl/operand_register.sv
// operand_register: one WIDTH-bit register applying a 3-bit function when
// enabled.
//   Clock  : rising-edge clock
//   Reset  : synchronous active-high; loads RESET_VAL, overrides E/FunSel
//   E      : write enable
//   FunSel : DEC, INC, LOAD, CLR, LDLB, LDLH, SHB, SEXH (see cpu_pkg)
//   I      : write data
//   Q      : current register contents
// Build option: define REGFILE_SAT_COUNT_EN to make INC/DEC saturate at
// all-ones / zero instead of wrapping.
module operand_register
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = cpu_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (reg_fun_e'(FunSel))
`ifdef REGFILE_SAT_COUNT_EN
      REG_DEC:  q_d = (q_q == '0) ? q_q : q_q - ONE;
      REG_INC:  q_d = (q_q == '1) ? q_q : q_q + ONE;
`else
      REG_DEC:  q_d = q_q - ONE;
      REG_INC:  q_d = q_q + ONE;
`endif
      REG_LOAD: q_d = I;
      REG_CLR:  q_d = '0;
      REG_LDLB: q_d = {{(WIDTH-8){1'b0}}, I[7:0]};
      REG_LDLH: q_d = {q_q[WIDTH-1:16], I[15:0]};
      // Byte-packing: old contents move up one byte, new byte enters at bottom.
      REG_SHB:  q_d = {q_q[WIDTH-9:0], I[7:0]};
      REG_SEXH: q_d = {{(WIDTH-16){I[15]}}, I[15:0]};
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q <= RESET_VAL;
    end else if (E) begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/alu_operand_regfile.sv
// alu_operand_regfile: eight operand registers (R1-R4 general, S1-S4
// scratch) feeding ALU inputs A and B.
//   Clock, Reset     : rising-edge clock, synchronous active-high reset
//   I                : shared write data bus
//   FunSel           : function applied to every enabled register
//   RegSel / ScrSel  : per-register write enables, bit0 = R1 / S1
//   OutASel/OutBSel  : read selects, 0..3 = R1..R4, 4..7 = S1..S4
//   OutA / OutB      : combinational read data (no write bypass)
// Build option: REGFILE_SAT_COUNT_EN selects saturating INC/DEC.
module alu_operand_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = cpu_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = 32'h0000_0000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  // Index order matches the read-select encoding: R1..R4 then S1..S4.
  logic [7:0]       en;
  logic [WIDTH-1:0] reg_q [8];

  assign en = {ScrSel, RegSel};

  for (genvar g = 0; g < 8; g++) begin : g_reg
    operand_register #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_reg (
      .Clock (Clock),
      .Reset (Reset),
      .E     (en[g]),
      .FunSel(FunSel),
      .I     (I),
      .Q     (reg_q[g])
    );
  end

  always_comb begin
    OutA = '0;
    case (reg_sel_e'(OutASel))
      SEL_R1:  OutA = reg_q[0];
      SEL_R2:  OutA = reg_q[1];
      SEL_R3:  OutA = reg_q[2];
      SEL_R4:  OutA = reg_q[3];
      SEL_S1:  OutA = reg_q[4];
      SEL_S2:  OutA = reg_q[5];
      SEL_S3:  OutA = reg_q[6];
      SEL_S4:  OutA = reg_q[7];
      default: OutA = '0;
    endcase
  end

  always_comb begin
    OutB = '0;
    case (reg_sel_e'(OutBSel))
      SEL_R1:  OutB = reg_q[0];
      SEL_R2:  OutB = reg_q[1];
      SEL_R3:  OutB = reg_q[2];
      SEL_R4:  OutB = reg_q[3];
      SEL_S1:  OutB = reg_q[4];
      SEL_S2:  OutB = reg_q[5];
      SEL_S3:  OutB = reg_q[6];
      SEL_S4:  OutB = reg_q[7];
      default: OutB = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_regfile.sv
module tb_alu_operand_regfile;

`ifdef REGFILE_SAT_COUNT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [2:0]  fun;
  logic [3:0]  rsel;
  logic [3:0]  ssel;
  logic [2:0]  asel;
  logic [2:0]  bsel;
  logic [31:0] outa;
  logic [31:0] outb;

  int checks;
  int failures;

  alu_operand_regfile #(
    .WIDTH    (32),
    .RESET_VAL(32'h0000_0000)
  ) dut (
    .Clock  (clk),
    .Reset  (rst),
    .I      (din),
    .FunSel (fun),
    .RegSel (rsel),
    .ScrSel (ssel),
    .OutASel(asel),
    .OutBSel(bsel),
    .OutA   (outa),
    .OutB   (outb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [2:0]  fun;
    logic [3:0]  rs;
    logic [3:0]  ss;
    logic [31:0] i;
    logic [2:0]  asel;
    logic [2:0]  bsel;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t v [20];
  logic [31:0] final_exp [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] f, input logic [3:0] rs,
                              input logic [3:0] ss, input logic [31:0] i,
                              input logic [2:0] a, input logic [2:0] b,
                              input logic [31:0] ea, input logic [31:0] eb);
    vec_t t;
    t.rst = r; t.fun = f; t.rs = rs; t.ss = ss; t.i = i;
    t.asel = a; t.bsel = b; t.ea = ea; t.eb = eb;
    return t;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; din = '0; fun = 3'b000; rsel = '0; ssel = '0; asel = '0; bsel = '0;

    // FunSel: 0 DEC 1 INC 2 LOAD 3 CLR 4 LDLB 5 LDLH 6 SHB 7 SEXH
    // Sel:    0..3 R1..R4, 4..7 S1..S4
    v[0]  = mk(1, 3'd2, 4'hF, 4'hF, 32'hDEAD_BEEF, 3'd0, 3'd7, 32'h0, 32'h0);
    v[1]  = mk(0, 3'd2, 4'b0010, 4'b0000, 32'h1234_5678, 3'd1, 3'd0, 32'h1234_5678, 32'h0);
    v[2]  = mk(0, 3'd5, 4'b0010, 4'b0000, 32'h0000_ABCD, 3'd1, 3'd2, 32'h1234_ABCD, 32'h0);
    v[3]  = mk(0, 3'd7, 4'b0100, 4'b0000, 32'h0000_8001, 3'd2, 3'd1, 32'hFFFF_8001, 32'h1234_ABCD);
    v[4]  = mk(0, 3'd3, 4'b0000, 4'b0001, 32'h5555_5555, 3'd4, 3'd2, 32'h0, 32'hFFFF_8001);
    v[5]  = mk(0, 3'd0, 4'b0000, 4'b0001, 32'h0, 3'd4, 3'd5,
               SAT ? 32'h0 : 32'hFFFF_FFFF, 32'h0);
    v[6]  = mk(0, 3'd1, 4'b0000, 4'b0001, 32'h0, 3'd4, 3'd1,
               SAT ? 32'h1 : 32'h0, 32'h1234_ABCD);
    v[7]  = mk(0, 3'd2, 4'b0000, 4'b0001, 32'hFFFF_FFFF, 3'd4, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_8001);
    v[8]  = mk(0, 3'd1, 4'b0000, 4'b0001, 32'h0, 3'd4, 3'd7,
               SAT ? 32'hFFFF_FFFF : 32'h0, 32'h0);
    v[9]  = mk(0, 3'd3, 4'b0001, 4'b0000, 32'h7777_7777, 3'd0, 3'd4,
               32'h0, SAT ? 32'hFFFF_FFFF : 32'h0);
    v[10] = mk(0, 3'd6, 4'b0001, 4'b0000, 32'hAABB_CC11, 3'd0, 3'd1, 32'h0000_0011, 32'h1234_ABCD);
    v[11] = mk(0, 3'd6, 4'b0001, 4'b0000, 32'h5566_7722, 3'd0, 3'd1, 32'h0000_1122, 32'h1234_ABCD);
    v[12] = mk(0, 3'd6, 4'b0001, 4'b0000, 32'h9988_7733, 3'd0, 3'd1, 32'h0011_2233, 32'h1234_ABCD);
    v[13] = mk(0, 3'd6, 4'b0001, 4'b0000, 32'hDEAD_BE44, 3'd0, 3'd1, 32'h1122_3344, 32'h1234_ABCD);
    v[14] = mk(0, 3'd4, 4'b0001, 4'b0000, 32'hFFFF_FF80, 3'd0, 3'd2, 32'h0000_0080, 32'hFFFF_8001);
    v[15] = mk(0, 3'd2, 4'b0001, 4'b0000, 32'h0000_0005, 3'd0, 3'd2, 32'h5, 32'hFFFF_8001);
    v[16] = mk(0, 3'd2, 4'b0100, 4'b0000, 32'h0000_0009, 3'd2, 3'd0, 32'h9, 32'h5);
    v[17] = mk(0, 3'd3, 4'b0000, 4'b0010, 32'hFFFF_FFFF, 3'd5, 3'd2, 32'h0, 32'h9);
    v[18] = mk(0, 3'd1, 4'b0101, 4'b0010, 32'h0, 3'd0, 3'd2, 32'h6, 32'hA);
    v[19] = mk(0, 3'd2, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 3'd0, 3'd5, 32'h6, 32'h1);

    final_exp[0] = 32'h6;
    final_exp[1] = 32'h1234_ABCD;
    final_exp[2] = 32'hA;
    final_exp[3] = 32'h0;
    final_exp[4] = SAT ? 32'hFFFF_FFFF : 32'h0;
    final_exp[5] = 32'h1;
    final_exp[6] = 32'h0;
    final_exp[7] = 32'h0;

    // Table: drive at negedge, one rising edge, sample 1ns later.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rst = v[k].rst; fun = v[k].fun; rsel = v[k].rs; ssel = v[k].ss; din = v[k].i;
      asel = v[k].asel; bsel = v[k].bsel;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_A", k), outa, v[k].ea);
      chk($sformatf("vec%0d_B", k), outb, v[k].eb);
      if (k == 0) begin
        // All eight registers cleared by the reset despite LOAD + all enables.
        @(negedge clk);
        rst = 1'b0; rsel = '0; ssel = '0;
        for (int s = 0; s < 8; s++) begin
          asel = 3'(s); bsel = 3'(7 - s);
          #1;
          chk($sformatf("reset_rd%0d_A", s), outa, 32'h0);
          chk($sformatf("reset_rd%0d_B", s), outb, 32'h0);
        end
      end
    end

    // Full readback: only enabled registers changed in the simultaneous INC.
    @(negedge clk);
    rsel = '0; ssel = '0;
    for (int s = 0; s < 8; s++) begin
      asel = 3'(s); bsel = 3'(7 - s);
      #1;
      chk($sformatf("final_rd%0d_A", s), outa, final_exp[s]);
      chk($sformatf("final_rd%0d_B", s), outb, final_exp[7 - s]);
    end

    // Read-during-write on R4, both ports on the same register.
    @(negedge clk);
    asel = 3'd3; bsel = 3'd3;
    fun = 3'd2; rsel = 4'b1000; ssel = '0; din = 32'hCAFE_0001;
    #1;
    chk("rdw_pre_A", outa, 32'h0);
    chk("rdw_pre_B", outb, 32'h0);
    @(posedge clk);
    #1;
    chk("rdw_post_A", outa, 32'hCAFE_0001);
    chk("rdw_post_B", outb, 32'hCAFE_0001);

    // Start a count on S1, then reset lands on a LOAD/INC cycle.
    @(negedge clk);
    fun = 3'd2; rsel = '0; ssel = 4'b0001; din = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    fun = 3'd1;
    @(posedge clk);
    #1;
    asel = 3'd4;
    #1;
    chk("count_S1", outa, 32'h0000_0011);
    @(negedge clk);
    rst = 1'b1; fun = 3'd2; rsel = 4'b1000; ssel = 4'b0001; din = 32'h1234_5678;
    asel = 3'd3; bsel = 3'd4;
    @(posedge clk);
    #1;
    chk("rst_load_R4", outa, 32'h0);
    chk("rst_count_S1", outb, 32'h0);
    @(negedge clk);
    rst = 1'b0; rsel = '0; ssel = '0;
    asel = 3'd1; bsel = 3'd2;
    #1;
    chk("rst_R2", outa, 32'h0);
    chk("rst_R3", outb, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
